cache_l2_ctrl_fsm: RTL and testbench
====================================

// Module: cache_l2_ctrl_fsm
// PURPOSE
//  Parametrised L2 cache controller FSM. Pops one request (RD/WR/PWB) from the L2 request queue and runs a
//  tag lookup. Returns read data to one of NUM_UP upper buses, fills misses from the lower bus with a reply
//  timeout/retry, and writes WR/PWB lines through to the lower bus. One request in flight at a time.
// PARAMETERS
//  NUM_UP        2   number of upper (L1-side) buses; SRC_W = max(1,$clog2(NUM_UP))
//  UP_BEATS      1   cycles a read-hit data transfer holds an upper bus
//  LO_RATIO      4   core cycles per lower-bus beat
//  LO_ADDR_BEATS 1   lower-bus address beats
//  LO_DATA_BEATS 4   lower-bus data beats per line; BEAT_W = max(1,$clog2(LO_DATA_BEATS))
//  REPLY_TIMEOUT 64  max cycles in LO_WAIT before re-issuing the fetch; 0 = no timeout
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous reset, active low
//  req_valid      in   1       request queue not empty
//  req_op         in   2       00 RD, 01 WR, 10 PWB (11 treated as RD); valid while req_valid
//  req_src        in   SRC_W   upper bus that issued the request
//  req_pop        out  1       one-cycle pop strobe to queue
//  lookup_en      out  1       one-cycle tag-lookup strobe
//  hit            in   1       lookup result, valid the cycle after lookup_en
//  pwb_match      in   1       pending-writeback buffer holds this address
//  pwb_ready      in   1       matching PWB data fully received
//  up_req         out  NUM_UP  per-bus arbiter request
//  up_get         in   NUM_UP  per-bus grant
//  up_hold/up_dir out  NUM_UP  per-bus hold / drive direction (1 = L2 drives)
//  lo_req         out  1       lower arbiter request
//  lo_req_type    out  1       0 normal, 1 PWB write
//  lo_get         in   1       lower grant
//  lo_hold/lo_dir out  1       lower hold / direction (1 = L2 drives)
//  lo_reply       in   1       lower level returns fill data (one-cycle pulse)
//  tx_sel         out  1       lower transmitter: 0 address, 1 data
//  data_portion   out  BEAT_W  lower data beat index
//  data_out_sel   out  1       upper read data: 0 array, 1 PWB buffer
//  fill_sel       out  1       array write data: 0 request data, 1 lower-bus fill
//  wr_en/wr_tag_en out 1       array data / tag write enables
//  new_flag       out  1       mark written line valid/new
//  busy           out  1       state != IDLE
//  err_timeout    out  1       one-cycle pulse on reply timeout
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all outputs 0, state IDLE, counters 0, no latched request.
//   - Mid-transfer reset drops every req/hold immediately; no resume after reset.
//  States: IDLE, LOOKUP, DECIDE, PWB_CHK, UP_REQ, UP_SEND, WR_LOCAL, LO_REQ, LO_ADDR, LO_DATA, LO_WAIT, FILL1, FILL2.
//  IDLE:
//   - On req_valid: req_pop=1 for 1 cycle; latch op and src; -> LOOKUP.
//  LOOKUP:
//   - lookup_en=1 for 1 cycle; -> DECIDE.
//  DECIDE (samples hit):
//   - RD hit -> PWB_CHK.
//   - RD miss -> LO_REQ (fetch).
//   - WR/PWB hit -> WR_LOCAL.
//   - WR/PWB miss -> LO_REQ (fetch) with after_fill=WR.
//  PWB_CHK:
//   - Stall while pwb_match && !pwb_ready.
//   - Then data_out_sel=pwb_match, up_req[src]=1 -> UP_REQ.
//  UP_REQ:
//   - Wait up_get[src]; grants on other buses are ignored.
//   - -> UP_SEND with up_hold[src]=up_dir[src]=1.
//  UP_SEND:
//   - Exactly UP_BEATS cycles, then clear up_req/hold/dir -> IDLE.
//  WR_LOCAL:
//   - wr_en=1, new_flag=1, fill_sel=0 for 1 cycle.
//   - -> LO_REQ (write-through); lo_req_type=(op==PWB).
//  LO_REQ:
//   - lo_req=1 until lo_get.
//   - On lo_get: lo_hold=lo_dir=1, tx_sel=0 -> LO_ADDR.
//  LO_ADDR:
//   - Lasts LO_ADDR_BEATS*LO_RATIO cycles.
//   - Fetch: release lower bus (req/hold/dir/type 0) -> LO_WAIT.
//   - Write: tx_sel=1, data_portion=LO_DATA_BEATS-1 -> LO_DATA.
//  LO_DATA:
//   - Lasts LO_DATA_BEATS*LO_RATIO cycles.
//   - data_portion decrements by 1 every LO_RATIO cycles; final beat index 0.
//   - Then release lower bus -> IDLE.
//  LO_WAIT:
//   - lo_reply -> FILL1.
//   - Timeout counter increments each cycle; at REPLY_TIMEOUT: err_timeout pulse, -> LO_REQ (re-issue).
//   - lo_reply in the same cycle as expiry: reply wins, no err pulse.
//  FILL1:
//   - wr_en=wr_tag_en=new_flag=fill_sel=1 for 1 cycle.
//  FILL2:
//   - Enables 0.
//   - -> WR_LOCAL if after_fill=WR, else PWB_CHK.
//  Counters:
//   - One down-counter, width $clog2 of the largest of UP_BEATS, LO_ADDR_BEATS*LO_RATIO,
//     LO_DATA_BEATS*LO_RATIO, REPLY_TIMEOUT, plus 1.
//   - Loaded with N-1 on state entry; exits at 0; no wrap.
//  Never pop while busy. req_valid is ignored outside IDLE.
// TESTING
//  1 RD hit, src=1, no PWB match, up_get[1] after 2 cycles -> up_hold[1] high exactly 1 cycle, up_req[0] never set, back to IDLE.
//  2 RD hit, pwb_match=1, pwb_ready rises 5 cycles later -> no up_req until then, then data_out_sel=1.
//  3 WR hit, lo_get immediate -> wr_en 1 cycle; lo_hold for 4+16 cycles; data_portion 3,2,1,0 each held 4 cycles.
//  4 PWB miss, lo_reply 10 cycles after address -> FILL1 with wr_tag_en=1, then WR_LOCAL, then lo_req_type=1 write.
//  5 RD miss, REPLY_TIMEOUT=8, no reply -> err_timeout pulse at cycle 8, lo_req re-raised; reply on retry completes fill.
//  6 rst_n low mid-LO_DATA -> lo_hold/lo_req/busy 0 asynchronously; after release, next req_valid pops normally.

Source files
------------

// File: rtl/cache_l2_ctrl_fsm.sv
// L2 cache controller FSM: one request in flight, tag lookup, upper-bus read return,
// lower-bus miss fill with reply timeout/retry, and write-through of WR/PWB lines.
module cache_l2_ctrl_fsm #(
   parameter  int NUM_UP        = 2,
   parameter  int UP_BEATS      = 1,
   parameter  int LO_RATIO      = 4,
   parameter  int LO_ADDR_BEATS = 1,
   parameter  int LO_DATA_BEATS = 4,
   parameter  int REPLY_TIMEOUT = 64,
   localparam int SRC_W         = (NUM_UP > 1) ? $clog2(NUM_UP) : 1,
   localparam int BEAT_W        = (LO_DATA_BEATS > 1) ? $clog2(LO_DATA_BEATS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [1:0]        req_op,
   input  logic [SRC_W-1:0]  req_src,
   output logic              req_pop,
   output logic              lookup_en,
   input  logic              hit,
   input  logic              pwb_match,
   input  logic              pwb_ready,
   output logic [NUM_UP-1:0] up_req,
   input  logic [NUM_UP-1:0] up_get,
   output logic [NUM_UP-1:0] up_hold,
   output logic [NUM_UP-1:0] up_dir,
   output logic              lo_req,
   output logic              lo_req_type,
   input  logic              lo_get,
   output logic              lo_hold,
   output logic              lo_dir,
   input  logic              lo_reply,
   output logic              tx_sel,
   output logic [BEAT_W-1:0] data_portion,
   output logic              data_out_sel,
   output logic              fill_sel,
   output logic              wr_en,
   output logic              wr_tag_en,
   output logic              new_flag,
   output logic              busy,
   output logic              err_timeout
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int ADDR_CYC = LO_ADDR_BEATS * LO_RATIO;
   localparam int DATA_CYC = LO_DATA_BEATS * LO_RATIO;
   localparam int CNT_MAX  = max2(max2(UP_BEATS, ADDR_CYC), max2(DATA_CYC, max2(REPLY_TIMEOUT, 1)));
   localparam int CNT_W    = $clog2(CNT_MAX) + 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_PWB = 2'b10,
      OP_RSV = 2'b11
   } op_t;

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOOKUP, ST_DECIDE, ST_PWB_CHK, ST_UP_REQ, ST_UP_SEND, ST_WR_LOCAL,
      ST_LO_REQ, ST_LO_ADDR, ST_LO_DATA, ST_LO_WAIT, ST_FILL1, ST_FILL2
   } state_t;

   state_t           state, state_nxt;
   cnt_t             cnt;
   op_t              op_q;
   logic [SRC_W-1:0] src_q;
   logic             fetch_q;
   logic             dsel_q;
   logic             is_wr;
   logic             timeout_hit;
   logic [NUM_UP-1:0] src_onehot;

   // Counter value on entry to a state: N-1 so the state lasts exactly N cycles.
   function automatic cnt_t load_val(input state_t s);
      unique case (s)
         ST_UP_SEND: return cnt_t'(UP_BEATS - 1);
         ST_LO_ADDR: return cnt_t'(ADDR_CYC - 1);
         ST_LO_DATA: return cnt_t'(DATA_CYC - 1);
         ST_LO_WAIT: return (REPLY_TIMEOUT == 0) ? '0 : cnt_t'(REPLY_TIMEOUT - 1);
         default:    return '0;
      endcase
   endfunction

   assign is_wr       = (op_q == OP_WR) || (op_q == OP_PWB);
   assign timeout_hit = (REPLY_TIMEOUT != 0) && (cnt == '0);
   assign src_onehot  = NUM_UP'(1) << src_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         op_q    <= OP_RD;
         src_q   <= '0;
         fetch_q <= 1'b0;
         dsel_q  <= 1'b0;
      end else begin
         // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         if (state_nxt != state) cnt <= load_val(state_nxt);
         else if (cnt != '0)     cnt <= cnt - cnt_t'(1);
         if (state == ST_IDLE && req_valid) begin
            op_q  <= op_t'(req_op);
            src_q <= req_src;
         end
         if (state == ST_DECIDE && !hit) fetch_q <= 1'b1;
         else if (state == ST_WR_LOCAL)  fetch_q <= 1'b0;
         if (state == ST_PWB_CHK && state_nxt == ST_UP_REQ) dsel_q <= pwb_match;
         else if (state_nxt == ST_IDLE)                     dsel_q <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      state_nxt    = state;
      req_pop      = 1'b0;
      lookup_en    = 1'b0;
      up_req       = '0;
      up_hold      = '0;
      up_dir       = '0;
      lo_req       = 1'b0;
      lo_req_type  = 1'b0;
      lo_hold      = 1'b0;
      lo_dir       = 1'b0;
      tx_sel       = 1'b0;
      data_portion = '0;
      data_out_sel = dsel_q;
      fill_sel     = 1'b0;
      wr_en        = 1'b0;
      wr_tag_en    = 1'b0;
      new_flag     = 1'b0;
      busy         = (state != ST_IDLE);
      err_timeout  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            // Gated with rst_n so the pop strobe is also silent while reset is held.
            req_pop = req_valid && rst_n;
            if (req_valid) state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            lookup_en = 1'b1;
            state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (!hit)       state_nxt = ST_LO_REQ;
            else if (is_wr) state_nxt = ST_WR_LOCAL;
            else            state_nxt = ST_PWB_CHK;
         end
         ST_PWB_CHK: begin
            if (!(pwb_match && !pwb_ready)) state_nxt = ST_UP_REQ;
         end
         ST_UP_REQ: begin
            up_req = src_onehot;
            if (up_get[src_q]) state_nxt = ST_UP_SEND;
         end
         ST_UP_SEND: begin
            up_req  = src_onehot;
            up_hold = src_onehot;
            up_dir  = src_onehot;
            if (cnt == '0) state_nxt = ST_IDLE;
         end
         ST_WR_LOCAL: begin
            wr_en     = 1'b1;
            new_flag  = 1'b1;
            state_nxt = ST_LO_REQ;
         end
         ST_LO_REQ: begin
            lo_req      = 1'b1;
            lo_req_type = !fetch_q && (op_q == OP_PWB);
            if (lo_get) state_nxt = ST_LO_ADDR;
         end
         ST_LO_ADDR: begin
            lo_req      = 1'b1;
            lo_req_type = !fetch_q && (op_q == OP_PWB);
            lo_hold     = 1'b1;
            lo_dir      = 1'b1;
            if (cnt == '0) state_nxt = fetch_q ? ST_LO_WAIT : ST_LO_DATA;
         end
         ST_LO_DATA: begin
            lo_req       = 1'b1;
            lo_req_type  = (op_q == OP_PWB);
            lo_hold      = 1'b1;
            lo_dir       = 1'b1;
            tx_sel       = 1'b1;
            // Beat index steps down once per LO_RATIO cycles, reaching 0 on the last beat.
            data_portion = BEAT_W'(cnt / cnt_t'(LO_RATIO));
            if (cnt == '0) state_nxt = ST_IDLE;
         end
         ST_LO_WAIT: begin
            if (lo_reply) begin
               state_nxt = ST_FILL1;
            end else if (timeout_hit) begin
               err_timeout = 1'b1;
               state_nxt   = ST_LO_REQ;
            end
         end
         ST_FILL1: begin
            wr_en     = 1'b1;
            wr_tag_en = 1'b1;
            new_flag  = 1'b1;
            fill_sel  = 1'b1;
            state_nxt = ST_FILL2;
         end
         ST_FILL2: begin
            state_nxt = is_wr ? ST_WR_LOCAL : ST_PWB_CHK;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_l2_ctrl_fsm.sv
// Directed bench for cache_l2_ctrl_fsm: a cycle table for a read hit plus hand-written
// sequences for PWB stall, write-through, miss fill, reply timeout and mid-transfer reset.
module tb_cache_l2_ctrl_fsm;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01, PWB = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_op = 2'b00;
   logic       req_src = 1'b0;
   logic       hit = 1'b0, pwb_match = 1'b0, pwb_ready = 1'b0;
   logic [1:0] up_get = 2'b00;
   logic       lo_get = 1'b0, lo_reply = 1'b0;

   // Instance a: default parameters
   logic       req_pop, lookup_en, lo_req, lo_req_type, lo_hold, lo_dir, tx_sel;
   logic [1:0] up_req, up_hold, up_dir, data_portion;
   logic       data_out_sel, fill_sel, wr_en, wr_tag_en, new_flag, busy, err_timeout;
   // Instance b: REPLY_TIMEOUT = 8
   logic       req_pop_b, lookup_en_b, lo_req_b, lo_req_type_b, lo_hold_b, lo_dir_b, tx_sel_b;
   logic [1:0] up_req_b, up_hold_b, up_dir_b, data_portion_b;
   logic       data_out_sel_b, fill_sel_b, wr_en_b, wr_tag_en_b, new_flag_b, busy_b, err_timeout_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_l2_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_src(req_src),
      .req_pop(req_pop), .lookup_en(lookup_en), .hit(hit), .pwb_match(pwb_match),
      .pwb_ready(pwb_ready), .up_req(up_req), .up_get(up_get), .up_hold(up_hold),
      .up_dir(up_dir), .lo_req(lo_req), .lo_req_type(lo_req_type), .lo_get(lo_get),
      .lo_hold(lo_hold), .lo_dir(lo_dir), .lo_reply(lo_reply), .tx_sel(tx_sel),
      .data_portion(data_portion), .data_out_sel(data_out_sel), .fill_sel(fill_sel),
      .wr_en(wr_en), .wr_tag_en(wr_tag_en), .new_flag(new_flag), .busy(busy),
      .err_timeout(err_timeout)
   );

   cache_l2_ctrl_fsm #(.REPLY_TIMEOUT(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_src(req_src),
      .req_pop(req_pop_b), .lookup_en(lookup_en_b), .hit(hit), .pwb_match(pwb_match),
      .pwb_ready(pwb_ready), .up_req(up_req_b), .up_get(up_get), .up_hold(up_hold_b),
      .up_dir(up_dir_b), .lo_req(lo_req_b), .lo_req_type(lo_req_type_b), .lo_get(lo_get),
      .lo_hold(lo_hold_b), .lo_dir(lo_dir_b), .lo_reply(lo_reply), .tx_sel(tx_sel_b),
      .data_portion(data_portion_b), .data_out_sel(data_out_sel_b), .fill_sel(fill_sel_b),
      .wr_en(wr_en_b), .wr_tag_en(wr_tag_en_b), .new_flag(new_flag_b), .busy(busy_b),
      .err_timeout(err_timeout_b)
   );

   wire [21:0] all_out_a = {req_pop, lookup_en, up_req, up_hold, up_dir, lo_req, lo_req_type,
                            lo_hold, lo_dir, tx_sel, data_portion, data_out_sel, fill_sel,
                            wr_en, wr_tag_en, new_flag, busy, err_timeout};
   wire [21:0] all_out_b = {req_pop_b, lookup_en_b, up_req_b, up_hold_b, up_dir_b, lo_req_b,
                            lo_req_type_b, lo_hold_b, lo_dir_b, tx_sel_b, data_portion_b,
                            data_out_sel_b, fill_sel_b, wr_en_b, wr_tag_en_b, new_flag_b,
                            busy_b, err_timeout_b};

   typedef struct {
      logic       rv;
      logic [1:0] op;
      logic       src;
      logic       hit;
      logic [1:0] get;
      logic       pop;
      logic       lk;
      logic [1:0] ureq;
      logic [1:0] uhold;
      logic       busy;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 1'b1;
      hit = 1'b0; pwb_match = 1'b0; pwb_ready = 1'b0;
      up_get = '0; lo_get = 1'b0; lo_reply = 1'b0;
      #1;
      check("reset_outputs_a", 32'(all_out_a), 32'd0);
      check("reset_outputs_b", 32'(all_out_b), 32'd0);
      repeat (2) @(posedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // Pop, lookup and decide; returns one cycle into the state chosen by DECIDE.
   task automatic issue(input logic [1:0] op, input logic src, input logic h);
      req_valid = 1'b1; req_op = op; req_src = src;
      tick();
      req_valid = 1'b0;
      tick();
      hit = h;
      tick();
      hit = 1'b0;
   endtask

   // From LO_REQ: grant the lower bus and step through the 4-cycle address phase.
   task automatic lo_grant_addr();
      lo_get = 1'b1;
      tick();
      repeat (4) tick();
      lo_get = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_tx, n_hold, n_badtype;
      bit done;

      // rv op src hit get | pop lk ureq uhold busy
      tbl[0] = '{1'b1, RD, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0}; // IDLE pop
      tbl[1] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1}; // LOOKUP
      tbl[2] = '{1'b0, RD, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1}; // DECIDE hit
      tbl[3] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1}; // PWB_CHK
      tbl[4] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1}; // UP_REQ
      tbl[5] = '{1'b0, RD, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1}; // other grant
      tbl[6] = '{1'b0, RD, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1}; // own grant
      tbl[7] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1}; // UP_SEND
      tbl[8] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0}; // IDLE
      tbl[9] = '{1'b0, RD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

      // Test 1: read hit on bus 1
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req_valid = tbl[i].rv; req_op = tbl[i].op; req_src = tbl[i].src;
         hit = tbl[i].hit; up_get = tbl[i].get;
         @(negedge clk);
         check($sformatf("t1_pop[%0d]", i), 32'(req_pop), 32'(tbl[i].pop));
         check($sformatf("t1_lookup[%0d]", i), 32'(lookup_en), 32'(tbl[i].lk));
         check($sformatf("t1_up_req[%0d]", i), 32'(up_req), 32'(tbl[i].ureq));
         check($sformatf("t1_up_hold[%0d]", i), 32'(up_hold), 32'(tbl[i].uhold));
         check($sformatf("t1_up_dir[%0d]", i), 32'(up_dir), 32'(tbl[i].uhold));
         check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
         tick();
      end
      hit = 1'b0; up_get = '0;

      // Test 2: read hit stalled on pending writeback
      do_reset();
      pwb_match = 1'b1; pwb_ready = 1'b0;
      issue(RD, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         settle();
         check("t2_stall_up_req", 32'(up_req), 32'd0);
         check("t2_stall_busy", 32'(busy), 32'd1);
         tick();
      end
      pwb_ready = 1'b1;
      settle();
      check("t2_exit_up_req", 32'(up_req), 32'd0);
      tick();
      settle();
      check("t2_up_req", 32'(up_req), 32'b01);
      check("t2_data_out_sel", 32'(data_out_sel), 32'd1);
      up_get = 2'b01;
      tick();
      up_get = 2'b00;
      settle();
      check("t2_up_hold", 32'(up_hold), 32'b01);
      check("t2_data_out_sel_send", 32'(data_out_sel), 32'd1);
      tick();
      settle();
      check("t2_idle_busy", 32'(busy), 32'd0);
      check("t2_idle_data_out_sel", 32'(data_out_sel), 32'd0);
      pwb_match = 1'b0; pwb_ready = 1'b0;

      // Test 3: write hit, write-through with beat countdown; req_valid held to check no pop
      do_reset();
      issue(WR, 1'b0, 1'b1);
      settle();
      check("t3_wr_local", 32'({wr_en, wr_tag_en, new_flag, fill_sel}), 32'b1010);
      check("t3_wr_local_lo_req", 32'(lo_req), 32'd0);
      lo_get = 1'b1;
      tick();
      settle();
      check("t3_lo_req", 32'(lo_req), 32'd1);
      check("t3_lo_req_hold", 32'(lo_hold), 32'd0);
      check("t3_wr_en_once", 32'(wr_en), 32'd0);
      check("t3_req_type", 32'(lo_req_type), 32'd0);
      tick();
      req_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         settle();
         check("t3_lo_hold", 32'({lo_hold, lo_dir, lo_req}), 32'b111);
         check("t3_no_pop_busy", 32'(req_pop), 32'd0);
         if (k < 4) begin
            check("t3_addr_tx_sel", 32'(tx_sel), 32'd0);
         end else begin
            check("t3_data_tx_sel", 32'(tx_sel), 32'd1);
            check($sformatf("t3_portion[%0d]", k), 32'(data_portion), 32'(3 - (k - 4) / 4));
         end
         tick();
      end
      settle();
      check("t3_released", 32'({lo_req, lo_hold, lo_dir, tx_sel, busy}), 32'd0);
      check("t3_pop_in_idle", 32'(req_pop), 32'd1);
      req_valid = 1'b0; lo_get = 1'b0;

      // Test 4: PWB miss, fill after 10 cycles of wait, then PWB write-through
      do_reset();
      issue(PWB, 1'b0, 1'b0);
      settle();
      check("t4_fetch_req", 32'({lo_req, lo_req_type}), 32'b10);
      lo_grant_addr();
      for (int k = 1; k < 10; k++) begin
         settle();
         check("t4_wait_released", 32'({lo_req, lo_hold, busy}), 32'b001);
         tick();
      end
      lo_reply = 1'b1;
      tick();
      lo_reply = 1'b0;
      settle();
      check("t4_fill1", 32'({wr_en, wr_tag_en, new_flag, fill_sel}), 32'b1111);
      tick();
      settle();
      check("t4_fill2", 32'({wr_en, wr_tag_en, new_flag, fill_sel}), 32'b0000);
      tick();
      settle();
      check("t4_wr_local", 32'({wr_en, wr_tag_en, new_flag, fill_sel}), 32'b1010);
      lo_get = 1'b1;
      tick();
      settle();
      check("t4_wb_req", 32'({lo_req, lo_req_type}), 32'b11);
      n_tx = 0; n_hold = 0; n_badtype = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         tick();
         settle();
         if (!busy) done = 1'b1;
         if (tx_sel) n_tx++;
         if (lo_hold) begin
            n_hold++;
            if (!lo_req_type) n_badtype++;
         end
      end
      lo_get = 1'b0;
      check("t4_done", 32'(done), 32'd1);
      check("t4_data_cycles", 32'(n_tx), 32'd16);
      check("t4_hold_cycles", 32'(n_hold), 32'd20);
      check("t4_type_low", 32'(n_badtype), 32'd0);

      // Test 5: read miss on timeout-8 instance, timeout then successful retry
      do_reset();
      issue(RD, 1'b1, 1'b0);
      lo_grant_addr();
      for (int k = 1; k <= 8; k++) begin
         settle();
         check($sformatf("t5_err[%0d]", k), 32'(err_timeout_b), 32'(k == 8));
         tick();
      end
      settle();
      check("t5_retry_req", 32'({lo_req_b, err_timeout_b}), 32'b10);
      lo_grant_addr();
      lo_reply = 1'b1;
      settle();
      check("t5_reply_no_err", 32'(err_timeout_b), 32'd0);
      tick();
      lo_reply = 1'b0;
      settle();
      check("t5_fill1", 32'({wr_tag_en_b, fill_sel_b}), 32'b11);
      tick();
      tick();
      tick();
      settle();
      check("t5_up_req", 32'(up_req_b), 32'b10);
      up_get = 2'b10;
      tick();
      up_get = 2'b00;
      settle();
      check("t5_up_hold", 32'(up_hold_b), 32'b10);
      tick();
      settle();
      check("t5_idle", 32'(busy_b), 32'd0);

      // Test 5b: reply on the expiry cycle wins over the timeout
      do_reset();
      issue(RD, 1'b0, 1'b0);
      lo_grant_addr();
      repeat (7) tick();
      lo_reply = 1'b1;
      settle();
      check("t5b_no_err", 32'(err_timeout_b), 32'd0);
      tick();
      lo_reply = 1'b0;
      settle();
      check("t5b_fill1", 32'({fill_sel_b, lo_req_b}), 32'b10);

      // Test 6: asynchronous reset in the middle of LO_DATA
      do_reset();
      issue(WR, 1'b0, 1'b1);
      lo_get = 1'b1;
      tick();
      repeat (5) tick();
      repeat (5) tick();
      settle();
      check("t6_in_data", 32'({tx_sel, lo_hold}), 32'b11);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async_drop", 32'({lo_hold, lo_req, busy, tx_sel}), 32'd0);
      lo_get = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      req_valid = 1'b1; req_op = RD; req_src = 1'b0;
      settle();
      check("t6_pop_after_reset", 32'(req_pop), 32'd1);
      tick();
      req_valid = 1'b0;
      settle();
      check("t6_lookup_after_reset", 32'(lookup_en), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
